// File: rtl/stage2_fmap_window_gen.sv
// KxK sliding-window generator for the stage2 conv input: raster pixels in, one packed
// CI x K x K window out per complete position, laid out for the CI accumulator.
module stage2_fmap_window_gen #(
  parameter int CI   = 3,
  parameter int IBW  = 20,
  parameter int K    = 5,
  parameter int IN_W = 12,
  parameter int IN_H = 12,
  localparam int PW  = CI*IBW,
  localparam int FW  = CI*K*K*IBW,
  localparam int XW  = $clog2(IN_W),
  localparam int YW  = $clog2(IN_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_in_valid,
  input  logic [PW-1:0] i_in_pixel,
  input  logic          i_clear,
  output logic          o_ot_valid,
  output logic [FW-1:0] o_ot_fmap,
  output logic [XW-1:0] o_ot_x,
  output logic [YW-1:0] o_ot_y,
  output logic          o_frame_done
);

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          acc, emit, col_last, row_last;

  logic [PW-1:0]                 lbuf [K-1][IN_W];
  logic [K-1:0][PW-1:0]          colv;
  logic [K-1:0][K-1:0][PW-1:0]   win, win_nxt;
  logic [FW-1:0]                 fmap_nxt;

  // Clear wins over a coincident pixel, so the pixel never touches any state.
  assign acc      = i_in_valid && !reset && !i_clear;
  assign col_last = (col == XW'(IN_W-1));
  assign row_last = (row == YW'(IN_H-1));
  assign emit     = acc && (col >= XW'(K-1)) && (row >= YW'(K-1));

  // Buffer j holds row-(j+1); read-before-write at col gives the vertical column.
  always_ff @(posedge clk) begin
    if (acc) begin
      lbuf[0][col] <= i_in_pixel;
      for (int j = 1; j < K-1; j++) lbuf[j][col] <= lbuf[j-1][col];
    end
  end

  always_comb begin
    colv      = '0;
    colv[K-1] = i_in_pixel;
    for (int ky = 0; ky < K-1; ky++) colv[ky] = lbuf[K-2-ky][col];
  end

  always_comb begin
    win_nxt = win;
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K-1; kx++) win_nxt[ky][kx] = win[ky][kx+1];
      win_nxt[ky][K-1] = colv[ky];
    end
  end

  always_ff @(posedge clk) begin
    if (acc) win <= win_nxt;
  end

  // Channel-major repack: element (c,ky,kx) at (c*K*K + ky*K + kx)*IBW.
  for (genvar c = 0; c < CI; c++) begin : g_ch
    for (genvar ky = 0; ky < K; ky++) begin : g_ky
      for (genvar kx = 0; kx < K; kx++) begin : g_kx
        assign fmap_nxt[(c*K*K + ky*K + kx)*IBW +: IBW] = win_nxt[ky][kx][c*IBW +: IBW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      col          <= '0;
      row          <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_x       <= '0;
      o_ot_y       <= '0;
      o_ot_fmap    <= '0;
    end else begin
      o_ot_valid   <= emit;
      o_frame_done <= acc && col_last && row_last;
      if (acc) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
      end
      if (emit) begin
        o_ot_fmap <= fmap_nxt;
        o_ot_x    <= col - XW'(K-1);
        o_ot_y    <= row - YW'(K-1);
      end
    end
  end

endmodule

// File: tb/tb_stage2_fmap_window_gen.sv
// Randomized bench for stage2_fmap_window_gen: an image-array model predicts every
// output cycle, and literal pins anchor the model to hand-computed windows.
module tb_stage2_fmap_window_gen;
  localparam int CI = 3, IBW = 20, K = 5, IN_W = 12, IN_H = 12;
  localparam int PW = CI*IBW, FW = CI*K*K*IBW;
  localparam int XW = $clog2(IN_W), YW = $clog2(IN_H);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_in_valid = 1'b0;
  logic [PW-1:0] i_in_pixel = '0;
  logic          i_clear = 1'b0;
  logic          o_ot_valid;
  logic [FW-1:0] o_ot_fmap;
  logic [XW-1:0] o_ot_x;
  logic [YW-1:0] o_ot_y;
  logic          o_frame_done;

  stage2_fmap_window_gen #(.CI(CI), .IBW(IBW), .K(K), .IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk(clk), .reset(reset), .i_in_valid(i_in_valid), .i_in_pixel(i_in_pixel),
    .i_clear(i_clear), .o_ot_valid(o_ot_valid), .o_ot_fmap(o_ot_fmap),
    .o_ot_x(o_ot_x), .o_ot_y(o_ot_y), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  logic [FW-1:0] obs_f[$];
  int            obs_x[$], obs_y[$], obs_pos[$], obs_d[$];
  int            ndone = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [IBW-1:0] el(input logic [FW-1:0] f, input int c, input int ky, input int kx);
    return f[(c*K*K + ky*K + kx)*IBW +: IBW];
  endfunction

  // Reference: store the current frame as an image, build each window straight from it.
  initial begin
    logic [PW-1:0] img [IN_H][IN_W];
    logic [FW-1:0] exp_f;
    int  mcol, mrow, exp_x, exp_y, pos;
    bit  exp_v, exp_done, armed;
    mcol = 0; mrow = 0; exp_x = 0; exp_y = 0; exp_f = '0; armed = 0; pos = 0;
    forever begin
      @(posedge clk);
      exp_v = 0; exp_done = 0;
      if (reset || i_clear) begin
        mcol = 0; mrow = 0; exp_x = 0; exp_y = 0; exp_f = '0; armed = 1;
      end else if (i_in_valid) begin
        img[mrow][mcol] = i_in_pixel;
        if (mrow >= K-1 && mcol >= K-1) begin
          exp_v = 1; exp_x = mcol-(K-1); exp_y = mrow-(K-1);
          pos = mrow*IN_W + mcol + 1;
          for (int c = 0; c < CI; c++)
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++)
                exp_f[(c*K*K + ky*K + kx)*IBW +: IBW] =
                  img[mrow-K+1+ky][mcol-K+1+kx][c*IBW +: IBW];
        end
        exp_done = (mrow == IN_H-1) && (mcol == IN_W-1);
        if (mcol == IN_W-1) begin
          mcol = 0;
          mrow = (mrow == IN_H-1) ? 0 : mrow + 1;
        end else mcol++;
      end
      @(negedge clk);
      if (armed) begin
        chk("valid", 32'(o_ot_valid), 32'(exp_v));
        chk("frame_done", 32'(o_frame_done), 32'(exp_done));
        chk("x", 32'(o_ot_x), 32'(exp_x));
        chk("y", 32'(o_ot_y), 32'(exp_y));
        checks++;
        if (o_ot_fmap !== exp_f) begin
          errors++;
          for (int i = 0; i < CI*K*K; i++)
            if (o_ot_fmap[i*IBW +: IBW] !== exp_f[i*IBW +: IBW]) begin
              $display("FAIL fmap elem %0d at x=%0d y=%0d: got 0x%0h expected 0x%0h",
                       i, exp_x, exp_y, o_ot_fmap[i*IBW +: IBW], exp_f[i*IBW +: IBW]);
              break;
            end
        end
        if (o_ot_valid) begin
          obs_f.push_back(o_ot_fmap); obs_x.push_back(int'(o_ot_x));
          obs_y.push_back(int'(o_ot_y)); obs_pos.push_back(pos);
          obs_d.push_back(int'(o_frame_done));
        end
        if (o_frame_done) ndone++;
      end
    end
  end

  task automatic drive(input bit v, input logic [PW-1:0] p, input bit clr, input bit rst);
    @(posedge clk); #1;
    i_in_valid = v; i_in_pixel = p; i_clear = clr; reset = rst;
  endtask

  function automatic logic [PW-1:0] mkpix(input int off, input int r, input int c);
    logic [PW-1:0] p;
    for (int ch = 0; ch < CI; ch++) p[ch*IBW +: IBW] = IBW'(off + ch*256 + r*16 + c);
    return p;
  endfunction

  task automatic idle(input int n);
    repeat (n) drive(0, PW'({$urandom, $urandom}), 0, 0);
  endtask

  task automatic send_frame(input int off, input int gap_pct, input int npix);
    for (int i = 0; i < npix; i++) begin
      if ($urandom_range(99) < gap_pct) idle($urandom_range(1, 3));
      drive(1, mkpix(off, i/IN_W, i%IN_W), 0, 0);
    end
  endtask

  task automatic clear_obs();
    obs_f.delete(); obs_x.delete(); obs_y.delete(); obs_pos.delete(); obs_d.delete();
    ndone = 0;
  endtask

  initial begin
    logic [FW-1:0] ref_f[$];
    int ref_x[$], ref_y[$];
    int bad, dsum;

    repeat (3) drive(0, '0, 0, 1);
    drive(0, '0, 0, 0);
    @(negedge clk);
    chk("reset_valid", 32'(o_ot_valid), 0);
    chk("reset_fmap_zero", 32'(o_ot_fmap != '0), 0);
    chk("reset_xy", {o_ot_x, o_ot_y}, 0);

    // 1: continuous frame
    clear_obs();
    send_frame(0, 0, IN_W*IN_H); idle(3);
    chk("t1_count", obs_f.size(), 64);
    if (obs_f.size() == 64) begin
      chk("t1_first_pos", obs_pos[0], 53);
      chk("t1_first_xy", {obs_x[0], obs_y[0]}, 0);
      chk("t1_e000", el(obs_f[0], 0, 0, 0), 'h000);
      chk("t1_e244", el(obs_f[0], 2, 4, 4), 'h244);
      chk("t1_last_x", obs_x[63], 7);
      chk("t1_last_y", obs_y[63], 7);
      chk("t1_done_last", obs_d[63], 1);
      dsum = 0; foreach (obs_d[i]) dsum += obs_d[i];
      chk("t1_done_once", dsum, 1);
      // 3: row-boundary window at r=5, x=0 covers rows 1..5
      chk("t3_pos", obs_pos[8], 65);
      chk("t3_top", el(obs_f[8], 0, 0, 0), 'h010);
      chk("t3_bot", el(obs_f[8], 1, 4, 4), 'h154);
      ref_f = obs_f; ref_x = obs_x; ref_y = obs_y;
    end

    // 2: random gaps, identical windows
    clear_obs();
    send_frame(0, 50, IN_W*IN_H); idle(3);
    chk("t2_count", obs_f.size(), 64);
    if (obs_f.size() == 64 && ref_f.size() == 64) begin
      bad = 0;
      foreach (obs_f[i])
        if (obs_f[i] !== ref_f[i] || obs_x[i] != ref_x[i] || obs_y[i] != ref_y[i]) bad++;
      chk("t2_same_windows", bad, 0);
    end

    // 4: back-to-back frames
    clear_obs();
    send_frame(0, 0, IN_W*IN_H);
    send_frame('h800, 0, IN_W*IN_H); idle(3);
    chk("t4_count", obs_f.size(), 128);
    chk("t4_done", ndone, 2);
    if (obs_f.size() == 128) begin
      chk("t4_f2_pos", obs_pos[64], 53);
      chk("t4_f2_e000", el(obs_f[64], 0, 0, 0), 'h800);
      chk("t4_f2_e244", el(obs_f[64], 2, 4, 4), 'hA44);
    end

    // 5: reset mid-frame after 70 pixels
    clear_obs();
    send_frame(0, 0, 70);
    drive(0, '0, 0, 1); drive(0, '0, 0, 1); drive(0, '0, 0, 0);
    idle(2);
    chk("t5_pre_count", obs_f.size(), 14);
    clear_obs();
    send_frame('h400, 30, IN_W*IN_H); idle(3);
    chk("t5_count", obs_f.size(), 64);
    if (obs_f.size() > 0) begin
      chk("t5_first_pos", obs_pos[0], 53);
      chk("t5_first_xy", {obs_x[0], obs_y[0]}, 0);
    end

    // 6: clear coincident with pixel (4,4)
    clear_obs();
    send_frame(0, 0, 52);
    drive(1, mkpix(0, 4, 4), 1, 0);
    idle(3);
    chk("t6_no_valid", obs_f.size(), 0);
    send_frame('h200, 0, IN_W*IN_H); idle(3);
    chk("t6_count", obs_f.size(), 64);
    if (obs_f.size() > 0) begin
      chk("t6_first_pos", obs_pos[0], 53);
      chk("t6_e000", el(obs_f[0], 0, 0, 0), 'h200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
